// File: rtl/ysyx_220053_div_ctrl.sv
// Front-end controller for the 64-bit iterative divider: operand preparation, divider handshake, result shaping.
// Optional macro YSYX_220053_DIV_FASTPATH_EN resolves divide-by-zero and signed overflow without the divider.
module ysyx_220053_div_ctrl #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [63:0]      in_src1,
  input  logic [63:0]      in_src2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             div_valid,
  input  logic             div_ready,
  output logic             div_signed,
  output logic [63:0]      div_dividend,
  output logic [63:0]      div_divisor,
  output logic             div_flush,
  input  logic             div_out_valid,
  input  logic [63:0]      div_quotient,
  input  logic [63:0]      div_remainder,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer occurs on a rising clk edge where valid and ready are both high;
  // a raised valid keeps its payload stable until that edge, and only flush may withdraw it.

`ifdef YSYX_220053_DIV_FASTPATH_EN
  localparam bit FAST_PATH = 1'b1;
`else
  localparam bit FAST_PATH = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state;
  logic        op_rem;
  logic        op_word;
  logic [63:0] prep_a;
  logic [63:0] prep_b;
  logic [63:0] min_neg;
  logic        div_zero;
  logic        sgn_ovf;
  logic        special;
  logic [63:0] special_raw;
  logic [63:0] div_raw;

  function automatic logic [63:0] shape_result(input logic word, input logic [63:0] raw);
    return word ? {{32{raw[31]}}, raw[31:0]} : raw;
  endfunction

  // W ops divide the extended low halves, so 64-bit checks on the prepared operands cover both widths.
  always_comb begin
    prep_a = in_src1;
    prep_b = in_src2;
    if (in_op[2]) begin
      if (in_op[0]) begin
        prep_a = {32'h0, in_src1[31:0]};
        prep_b = {32'h0, in_src2[31:0]};
      end else begin
        prep_a = {{32{in_src1[31]}}, in_src1[31:0]};
        prep_b = {{32{in_src2[31]}}, in_src2[31:0]};
      end
    end
  end

  always_comb begin
    min_neg     = in_op[2] ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    div_zero    = (prep_b == 64'h0);
    sgn_ovf     = ~in_op[0] && (prep_a == min_neg) && (prep_b == {64{1'b1}});
    special     = FAST_PATH && (div_zero || sgn_ovf);
    special_raw = 64'h0;
    if (div_zero) begin
      special_raw = in_op[1] ? prep_a : {64{1'b1}};
    end else if (sgn_ovf) begin
      special_raw = in_op[1] ? 64'h0 : prep_a;
    end
  end

  assign div_raw = op_rem ? div_remainder : div_quotient;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      op_rem       <= 1'b0;
      op_word      <= 1'b0;
      out_result   <= 64'h0;
      out_tag      <= '0;
      div_dividend <= 64'h0;
      div_divisor  <= 64'h0;
      div_signed   <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_rem       <= in_op[1];
            op_word      <= in_op[2];
            out_tag      <= in_tag;
            div_dividend <= prep_a;
            div_divisor  <= prep_b;
            div_signed   <= ~in_op[0];
            if (special) begin
              out_result <= shape_result(in_op[2], special_raw);
              state      <= DONE;
            end else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (div_ready) state <= WAIT;
        end
        WAIT: begin
          if (div_out_valid) begin
            out_result <= shape_result(op_word, div_raw);
            state      <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign div_valid = (state == ISSUE);
  assign out_valid = (state == DONE);
  assign div_flush = flush;
  assign dbg_state = state;

endmodule
